mem_port_arbiter: RTL and testbench

- Shares the single-port 8K x 18 program/data memory between two requesters: port 0 is the CPU control sequencer and port 1 is the display scanner that feeds the LCD driver.
- Serialises accesses through a fixed FSM: ADDR (address load) -> ACCESS (re/we strobe) -> WAIT (memory latency) -> DONE (completion).
- Returns read data and a one-cycle completion pulse to the owning port.
- Sits between the requesters and the Memory instance and replaces the direct MAR-to-memory path.

---
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the single-port 8K x 18 memory: CPU sequencer on port 0, display scanner on port 1.
// Optional macro MEM_ARB_RR_EN selects round-robin tie-breaking; without it port 0 wins every tie.
module mem_port_arbiter #(
    parameter int AW      = 13,
    parameter int DW      = 18,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          done0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          done1,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_re,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    localparam int CW = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ACCESS,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic          ptr_q, ptr_d;
    logic          seen_q, seen_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          sel1;

`ifdef MEM_ARB_RR_EN
    assign sel1 = req1 & (~req0 | ~ptr_q);
`else
    assign sel1 = req1 & ~req0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= 1'b1;
            seen_q   <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            seen_q   <= seen_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // The pointer is loaded with the winner on entry to ADDR, so it doubles as the owner of the
    // transaction in flight and as the last-grant reference for the next tie.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        seen_d   = seen_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        done0    = 1'b0;
        done1    = 1'b0;
        mem_re   = 1'b0;
        mem_we   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    ptr_d   = sel1;
                    seen_d  = 1'b1;
                    we_d    = sel1 ? we1 : we0;
                    addr_d  = sel1 ? addr1 : addr0;
                    wdata_d = sel1 ? wdata1 : wdata0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                gnt0    = ~ptr_q;
                gnt1    = ptr_q;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                mem_re  = ~we_q;
                mem_we  = we_q;
                cnt_d   = CW'(MEM_LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        if (ptr_q) rdata1_d = mem_rdata;
                        else       rdata0_d = mem_rdata;
                    end
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                done0   = ~ptr_q;
                done1   = ptr_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign owner     = ptr_q & seen_q;
    assign mem_addr  = busy ? addr_q : '0;
    assign mem_wdata = busy ? wdata_q : '0;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table-driven transactions, reset/tie/misbehaviour sequences and random traffic.
// Expected tie winners follow MEM_ARB_RR_EN when that macro is defined for the build.
module tb_mem_port_arbiter;

    localparam int AW  = 13;
    localparam int DW  = 18;
    localparam int LAT = 3;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk, rst;
    logic          req0, we0, gnt0, done0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0, rdata0;
    logic          req1, we1, gnt1, done1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1, rdata1;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_re, mem_we, busy, owner;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .done0(done0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .done1(done1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          r0, w0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          r1, w1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          drop;
    } txn_t;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return (a == 13'h0005) ? 18'h1ABCD : ({a, a[4:0]} ^ 18'h2D2D2);
    endfunction

    // Memory with LAT-cycle read pipeline; idle slots carry noise so mistimed captures show up.
    logic [DW-1:0] mem_arr [8192];
    bit            mem_v   [8192];
    logic [DW-1:0] pipe    [LAT];
    always @(posedge clk) begin
        if (mem_we) begin
            mem_arr[mem_addr] <= mem_wdata;
            mem_v[mem_addr]   <= 1'b1;
        end
        pipe[0] <= mem_re ? (mem_v[mem_addr] ? mem_arr[mem_addr] : init_val(mem_addr)) : 18'($urandom);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[LAT-1];

    // Reference state: what the memory should hold and what each port's rdata should show.
    logic [DW-1:0] sh   [8192];
    bit            sh_v [8192];
    int            ptr_m;
    logic [DW-1:0] exp_rd0, exp_rd1;
    int            n_chk, n_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic r0, input logic r1);
        if (r0 && !r1) return 0;
        if (r1 && !r0) return 1;
        return RR ? (1 - ptr_m) : 0;
    endfunction

    function automatic logic [DW-1:0] exp_mem(input logic [AW-1:0] a);
        return sh_v[a] ? sh[a] : init_val(a);
    endfunction

    // Called at a negedge while the DUT is IDLE; returns at the negedge of the IDLE cycle after DONE.
    task automatic issue(input txn_t t);
        int            win, bad;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d, rd;
        bad = 0;
        win = pick(t.r0, t.r1);
        w   = win ? t.w1 : t.w0;
        a   = win ? t.a1 : t.a0;
        d   = win ? t.d1 : t.d0;
        rd  = exp_mem(a);
        req0 = t.r0; we0 = t.w0; addr0 = t.a0; wdata0 = t.d0;
        req1 = t.r1; we1 = t.w1; addr1 = t.a1; wdata1 = t.d1;
        for (int k = 1; k <= 4 + LAT; k++) begin
            @(negedge clk);
            if (mem_re && mem_we) bad++;
            if (k == 1) begin
                chk("gnt", 32'({gnt1, gnt0}), 32'(win ? 2 : 1));
                chk("owner", 32'(owner), 32'(win));
                chk("mem_addr_gnt", 32'(mem_addr), 32'(a));
                chk("busy", 32'(busy), 32'd1);
                addr0  = addr0 ^ 13'h0300;  addr1  = addr1 ^ 13'h0300;
                wdata0 = wdata0 ^ 18'h2AAAA; wdata1 = wdata1 ^ 18'h2AAAA;
                if (t.drop) begin req0 = 1'b0; req1 = 1'b0; end
            end else if (k == 2) begin
                chk("strobe", 32'({mem_re, mem_we}), 32'({!w, w}));
                chk("mem_addr_acc", 32'(mem_addr), 32'(a));
                if (w) chk("mem_wdata", 32'(mem_wdata), 32'(d));
                if (gnt0 || gnt1 || done0 || done1) bad++;
            end else if (k == 3 + LAT) begin
                if (!w) begin
                    if (win == 1) exp_rd1 = rd;
                    else          exp_rd0 = rd;
                end
                chk("done", 32'({done1, done0}), 32'(win ? 2 : 1));
                chk("rdata0", 32'(rdata0), 32'(exp_rd0));
                chk("rdata1", 32'(rdata1), 32'(exp_rd1));
                chk("mem_addr_done", 32'(mem_addr), 32'(a));
                req0 = 1'b0; req1 = 1'b0;
            end else if (k == 4 + LAT) begin
                chk("idle_after", 32'({busy, done1, done0, gnt1, gnt0}), 32'd0);
            end else begin
                if (gnt0 || gnt1 || done0 || done1 || mem_re || mem_we) bad++;
            end
        end
        chk("quiet", 32'(bad), 32'd0);
        ptr_m = win;
        if (w) begin sh[a] = d; sh_v[a] = 1'b1; end
    endtask

    // Both ports request continuously for four back-to-back transactions.
    task automatic tie_run();
        int wins [4];
        int dts  [4];
        int nd, ng, cyc, wexp, wd;
        nd = 0; ng = 0; cyc = 0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 13'h0005;
        req1 = 1'b1; we1 = 1'b0; addr1 = 13'h1FFF;
        while (nd < 4 && cyc < 8 * (4 + LAT)) begin
            @(negedge clk);
            cyc++;
            if (gnt0 || gnt1) begin
                wexp = pick(1'b1, 1'b1);
                chk("tie_gnt", 32'({gnt1, gnt0}), 32'(wexp ? 2 : 1));
                if (ng < 4) wins[ng] = wexp;
                ng++;
                ptr_m = wexp;
            end
            if (done0 || done1) begin
                wd = (nd < ng && nd < 4) ? wins[nd] : 0;
                if (wd == 1) exp_rd1 = exp_mem(13'h1FFF);
                else         exp_rd0 = exp_mem(13'h0005);
                chk("tie_done", 32'({done1, done0}), 32'(wd ? 2 : 1));
                chk("tie_rdata0", 32'(rdata0), 32'(exp_rd0));
                chk("tie_rdata1", 32'(rdata1), 32'(exp_rd1));
                if (nd > 0) chk("tie_spacing", 32'(cyc - dts[nd-1]), 32'(4 + LAT));
                dts[nd] = cyc;
                nd++;
                if (nd == 4) begin req0 = 1'b0; req1 = 1'b0; end
            end
        end
        chk("tie_count", 32'(nd), 32'd4);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
    endtask

    txn_t tab [10];
    txn_t rt;
    int   bad_r;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_chk = 0; n_err = 0;
        ptr_m = 1; exp_rd0 = '0; exp_rd1 = '0;
        rst = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        #1;
        chk("reset_ctl", 32'({gnt0, gnt1, done0, done1, mem_re, mem_we, busy, owner}), 32'd0);
        chk("reset_rdata0", 32'(rdata0), 32'd0);
        chk("reset_rdata1", 32'(rdata1), 32'd0);
        chk("reset_mem", 32'({mem_addr, mem_wdata} != 0), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        //           r0    w0    a0        d0          r1    w1    a1        d1          drop
        tab[0] = '{1'b1, 1'b0, 13'h0005, 18'h00000, 1'b0, 1'b0, 13'h0000, 18'h00000, 1'b0};
        tab[1] = '{1'b0, 1'b0, 13'h0000, 18'h00000, 1'b1, 1'b1, 13'h1FFF, 18'h00041, 1'b0};
        tab[2] = '{1'b0, 1'b0, 13'h0000, 18'h00000, 1'b1, 1'b0, 13'h1FFF, 18'h00000, 1'b0};
        tab[3] = '{1'b1, 1'b1, 13'h0000, 18'h3FFFF, 1'b0, 1'b0, 13'h0000, 18'h00000, 1'b0};
        tab[4] = '{1'b1, 1'b0, 13'h0000, 18'h00000, 1'b0, 1'b0, 13'h0000, 18'h00000, 1'b0};
        tab[5] = '{1'b1, 1'b0, 13'h0100, 18'h00000, 1'b0, 1'b0, 13'h0000, 18'h00000, 1'b1};
        tab[6] = '{1'b1, 1'b0, 13'h0005, 18'h00000, 1'b1, 1'b1, 13'h0020, 18'h12345, 1'b0};
        tab[7] = '{1'b0, 1'b0, 13'h0000, 18'h00000, 1'b1, 1'b0, 13'h0020, 18'h00000, 1'b0};
        tab[8] = '{1'b1, 1'b1, 13'h1FFF, 18'h00000, 1'b1, 1'b0, 13'h0005, 18'h00000, 1'b0};
        tab[9] = '{1'b0, 1'b0, 13'h0000, 18'h00000, 1'b1, 1'b0, 13'h1FFF, 18'h00000, 1'b0};
        for (int i = 0; i < 10; i++) issue(tab[i]);

        // Reset asserted between edges while a port 0 read sits in WAIT.
        req0 = 1'b1; we0 = 1'b0; addr0 = 13'h0010; req1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_ctl", 32'({busy, mem_re, mem_we, done0, done1, gnt0, gnt1, owner}), 32'd0);
        chk("rst_async_rdata0", 32'(rdata0), 32'd0);
        chk("rst_async_rdata1", 32'(rdata1), 32'd0);
        req0 = 1'b0;
        ptr_m = 1; exp_rd0 = '0; exp_rd1 = '0;
        bad_r = 0;
        repeat (2) begin @(negedge clk); if (done0 || done1 || busy) bad_r++; end
        rst = 1'b0;
        repeat (LAT + 3) begin @(negedge clk); if (done0 || done1 || busy) bad_r++; end
        chk("rst_no_done", 32'(bad_r), 32'd0);
        rt = '{1'b1, 1'b0, 13'h0010, 18'h00000, 1'b0, 1'b0, 13'h0000, 18'h00000, 1'b0};
        issue(rt);

        tie_run();

        for (int i = 0; i < 60; i++) begin
            rt.r0   = 1'($urandom_range(0, 1));
            rt.r1   = rt.r0 ? 1'($urandom_range(0, 1)) : 1'b1;
            rt.w0   = 1'($urandom_range(0, 1));
            rt.w1   = 1'($urandom_range(0, 1));
            rt.a0   = 13'h1FF8 + 13'($urandom_range(0, 7));
            rt.a1   = 13'h1FF8 + 13'($urandom_range(0, 7));
            rt.d0   = 18'($urandom);
            rt.d1   = 18'($urandom);
            rt.drop = ($urandom_range(0, 3) == 0);
            issue(rt);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
